// File: rtl/sparse_psum_accumulator.sv
// sparse_psum_accumulator
// Consumer end of a sparse-CNN PE output stream. Each beat carries four signed
// products, each tagged with an output (row, col). Products are scatter-added
// into an ofmap_dim x ofmap_dim accumulator tile. When the tile's last beat is
// accepted, the tile is drained in raster order over a valid/ready interface.
//
// Ports:
//   clk, irst_n             clock, synchronous active-low reset
//   start                   clears the tile and opens accumulation (IDLE only)
//   in_valid/in_ready       input beat handshake (in_ready high only in ACC)
//   in_last                 final beat of the tile
//   in_channel              output channel tag of the beat
//   data_in                 four signed product lanes
//   data_in_rows/_cols      per-lane coordinates
//   out_valid/out_ready     drain handshake
//   out_channel             channel latched from the tile's first beat
//   data_out, out_row/col   drained accumulator word and its coordinate
//   done                    one-cycle pulse after the final drain handshake
//   err_channel             sticky: a beat arrived on a different channel
//   drop_count              saturating count of out-of-range lanes
module sparse_psum_accumulator #(
  parameter int col_length       = 5,
  parameter int doublewordLength = 16,
  parameter int acc_length       = 24,
  parameter int ofmap_dim        = 8
) (
  input  logic                          clk,
  input  logic                          irst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [5:0]                    in_channel,
  input  logic [4*doublewordLength-1:0] data_in,
  input  logic [4*col_length-1:0]       data_in_rows,
  input  logic [4*col_length-1:0]       data_in_cols,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [5:0]                    out_channel,
  output logic [acc_length-1:0]         data_out,
  output logic [col_length-1:0]         out_row,
  output logic [col_length-1:0]         out_col,
  output logic                          done,
  output logic                          err_channel,
  output logic [15:0]                   drop_count
);

  localparam int DEPTH = ofmap_dim * ofmap_dim;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so ofmap_dim == 2^col_length is representable.
  localparam logic [col_length:0]   DIM_C    = (col_length + 1)'(ofmap_dim);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [col_length-1:0] LAST_COL = col_length'(ofmap_dim - 1);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

  state_t                  state_reg;
  logic [acc_length-1:0]   entry_reg [DEPTH];
  logic [IDX_W-1:0]        idx_reg;
  logic                    first_beat_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic [5:0]              out_channel_reg;
  logic [acc_length-1:0]   data_out_reg;
  logic [col_length-1:0]   out_row_reg;
  logic [col_length-1:0]   out_col_reg;
  logic                    done_reg;
  logic                    err_channel_reg;
  logic [15:0]             drop_count_reg;

  // Per-lane decode: range check, flat index, sign-extended value.
  logic [3:0]              lane_ok;
  logic [IDX_W-1:0]        lane_idx [4];
  logic [acc_length-1:0]   lane_ext [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [col_length-1:0]              row;
    logic [col_length-1:0]              col;
    logic signed [doublewordLength-1:0] val;
    assign row          = data_in_rows[gi*col_length +: col_length];
    assign col          = data_in_cols[gi*col_length +: col_length];
    assign val          = data_in[gi*doublewordLength +: doublewordLength];
    assign lane_ok[gi]  = ({1'b0, row} < DIM_C) && ({1'b0, col} < DIM_C);
    // Truncation to IDX_W is harmless: the index is only used when in range.
    assign lane_idx[gi] = IDX_W'(row) * IDX_W'(ofmap_dim) + IDX_W'(col);
    assign lane_ext[gi] = acc_length'(val);
  end

  // Beat is taken this cycle and belongs to the tile's channel.
  logic ch_ok;
  logic acc_en;
  assign ch_ok  = first_beat_reg || (in_channel == out_channel_reg);
  assign acc_en = (state_reg == ACC) && in_valid && ch_ok;

  // Sum of every in-range lane per entry, so same-beat collisions all count.
  logic [acc_length-1:0] entry_add [DEPTH];
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      entry_add[e] = '0;
      for (int k = 0; k < 4; k++) begin
        if (lane_ok[k] && (lane_idx[k] == IDX_W'(e))) begin
          entry_add[e] = entry_add[e] + lane_ext[k];
        end
      end
    end
  end

  logic [2:0] n_bad;
  always_comb begin
    n_bad = '0;
    for (int k = 0; k < 4; k++) begin
      if (!lane_ok[k]) n_bad = n_bad + 3'd1;
    end
  end

  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_count_reg} + 17'(n_bad);

  // Entry 0 as it will be after this edge; the first drain word must already
  // include the tile's last beat.
  logic [acc_length-1:0] first_word;
  assign first_word = acc_en ? (entry_reg[0] + entry_add[0]) : entry_reg[0];

  logic [IDX_W-1:0] idx_inc;
  assign idx_inc = idx_reg + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!irst_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      first_beat_reg  <= 1'b0;
      in_ready_reg    <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_channel_reg <= '0;
      data_out_reg    <= '0;
      out_row_reg     <= '0;
      out_col_reg     <= '0;
      done_reg        <= 1'b0;
      err_channel_reg <= 1'b0;
      drop_count_reg  <= '0;
      for (int e = 0; e < DEPTH; e++) entry_reg[e] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            for (int e = 0; e < DEPTH; e++) entry_reg[e] <= '0;
            err_channel_reg <= 1'b0;
            drop_count_reg  <= '0;
            first_beat_reg  <= 1'b1;
            in_ready_reg    <= 1'b1;
            state_reg       <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            if (ch_ok) begin
              for (int e = 0; e < DEPTH; e++) entry_reg[e] <= entry_reg[e] + entry_add[e];
              drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
              if (first_beat_reg) out_channel_reg <= in_channel;
              first_beat_reg <= 1'b0;
            end else begin
              err_channel_reg <= 1'b1;
            end
            // A mismatched beat still terminates the tile when it is the last.
            if (in_last) begin
              state_reg     <= DRAIN;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              idx_reg       <= '0;
              out_row_reg   <= '0;
              out_col_reg   <= '0;
              data_out_reg  <= first_word;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx_reg == LAST_IDX) begin
              out_valid_reg <= 1'b0;
              done_reg      <= 1'b1;
              idx_reg       <= '0;
              state_reg     <= IDLE;
            end else begin
              idx_reg      <= idx_inc;
              data_out_reg <= entry_reg[idx_inc];
              if (out_col_reg == LAST_COL) begin
                out_col_reg <= '0;
                out_row_reg <= out_row_reg + col_length'(1);
              end else begin
                out_col_reg <= out_col_reg + col_length'(1);
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_channel = out_channel_reg;
  assign data_out    = data_out_reg;
  assign out_row     = out_row_reg;
  assign out_col     = out_col_reg;
  assign done        = done_reg;
  assign err_channel = err_channel_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_sparse_psum_accumulator.sv
module tb_sparse_psum_accumulator;
  localparam int CL  = 5;
  localparam int DW  = 16;
  localparam int AW  = 24;
  localparam int DIM = 8;

  logic          clk;
  logic          irst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [5:0]    in_channel;
  logic [4*DW-1:0] data_in;
  logic [4*CL-1:0] data_in_rows;
  logic [4*CL-1:0] data_in_cols;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_channel;
  logic [AW-1:0] data_out;
  logic [CL-1:0] out_row;
  logic [CL-1:0] out_col;
  logic          done;
  logic          err_channel;
  logic [15:0]   drop_count;

  sparse_psum_accumulator #(
    .col_length(CL), .doublewordLength(DW), .acc_length(AW), .ofmap_dim(DIM)
  ) dut (
    .clk(clk), .irst_n(irst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_channel(in_channel), .data_in(data_in),
    .data_in_rows(data_in_rows), .data_in_cols(data_in_cols),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .data_out(data_out), .out_row(out_row), .out_col(out_col),
    .done(done), .err_channel(err_channel), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model of the tile and scoreboard of expected drain words.
  logic [AW-1:0] mdl [DIM*DIM];
  logic [5:0]    mdl_ch;
  bit            mdl_first;
  bit            mdl_err;
  int            mdl_drop;
  logic [AW-1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk16(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [19:0] pk5(input int a, input int b, input int c, input int d);
    return {d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < DIM*DIM; e++) mdl[e] = '0;
    mdl_first = 1'b1;
    mdl_err   = 1'b0;
    mdl_drop  = 0;
    mdl_ch    = '0;
    check("in_ready_after_start", 32'(in_ready), 1);
  endtask

  task automatic beat(input logic [5:0] ch, input bit last, input logic [63:0] d,
                      input logic [19:0] r, input logic [19:0] c);
    int row, col;
    logic [15:0] v;
    in_channel   = ch;
    in_last      = last;
    data_in      = d;
    data_in_rows = r;
    data_in_cols = c;
    in_valid     = 1'b1;
    if (mdl_first || ch == mdl_ch) begin
      if (mdl_first) mdl_ch = ch;
      mdl_first = 1'b0;
      for (int k = 0; k < 4; k++) begin
        row = int'(r[k*5 +: 5]);
        col = int'(c[k*5 +: 5]);
        v   = d[k*16 +: 16];
        if (row < DIM && col < DIM) mdl[row*DIM + col] = mdl[row*DIM + col] + {{8{v[15]}}, v};
        else if (mdl_drop < 65535) mdl_drop++;
      end
    end else begin
      mdl_err = 1'b1;
    end
    if (last) for (int e = 0; e < DIM*DIM; e++) sb.push_back(mdl[e]);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drain up to stop_at words. bp selects the 1,0,0,1 out_ready pattern;
  // poke drives in_valid beats during the drain, which must be ignored.
  task automatic drain(input bit bp, input bit poke, input int stop_at);
    int k, cyc;
    bit ready, held;
    logic [AW-1:0] hd, exp;
    logic [CL-1:0] hr, hc;
    k = 0; cyc = 0; held = 1'b0;
    check("first_word_valid", 32'(out_valid), 1);
    check("in_ready_in_drain", 32'(in_ready), 0);
    check("out_channel", 32'(out_channel), 32'(mdl_ch));
    check("err_channel", 32'(err_channel), 32'(mdl_err));
    check("drop_count", 32'(drop_count), mdl_drop);
    while (k < stop_at && cyc < 1000) begin
      if (out_valid !== 1'b1) begin
        check("valid_during_drain", 32'(out_valid), 1);
        break;
      end
      if (held) begin
        check("hold_data", 32'(data_out), 32'(hd));
        check("hold_row", 32'(out_row), 32'(hr));
        check("hold_col", 32'(out_col), 32'(hc));
      end
      ready = !bp || (cyc % 4 == 0) || (cyc % 4 == 3);
      out_ready = ready;
      if (poke) begin
        in_valid     = 1'b1;
        in_last      = 1'b1;
        in_channel   = mdl_ch;
        data_in      = pk16(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        data_in_rows = '0;
        data_in_cols = '0;
        check("in_ready_poke", 32'(in_ready), 0);
      end
      if (ready) begin
        if (sb.size() == 0) begin
          check("scoreboard_underflow", 32'(sb.size()), 1);
        end else begin
          exp = sb.pop_front();
          check($sformatf("word%0d", k), 32'(data_out), 32'(exp));
        end
        check("out_row", 32'(out_row), k / DIM);
        check("out_col", 32'(out_col), k % DIM);
        check("done_early", 32'(done), 0);
        k++;
        held = 1'b0;
      end else begin
        hd = data_out; hr = out_row; hc = out_col;
        held = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    if (k < stop_at) check("drain_timeout", k, stop_at);
    if (stop_at == DIM*DIM) begin
      check("done_pulse", 32'(done), 1);
      check("valid_after_drain", 32'(out_valid), 0);
      @(negedge clk);
      check("done_clear", 32'(done), 0);
      check("scoreboard_empty", 32'(sb.size()), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    irst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_channel = '0; data_in = '0; data_in_rows = '0; data_in_cols = '0;
    out_ready = 1'b0;
    mdl_first = 1'b1; mdl_err = 1'b0; mdl_drop = 0; mdl_ch = '0;
    for (int e = 0; e < DIM*DIM; e++) mdl[e] = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_out_row", 32'(out_row), 0);
    check("rst_out_col", 32'(out_col), 0);
    check("rst_out_channel", 32'(out_channel), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_channel), 0);
    check("rst_drop", 32'(drop_count), 0);
    irst_n = 1'b1;
    @(negedge clk);

    // Basic scatter on channel 5.
    do_start();
    beat(6'd5, 1'b1, pk16(1, 2, 3, -4), pk5(0, 0, 1, 7), pk5(0, 1, 0, 7));
    drain(1'b0, 1'b0, 64);

    // Collisions: all four lanes on (2,3); a start mid-ACC must not clear.
    do_start();
    beat(6'd1, 1'b0, pk16(5, 5, 5, 5), pk5(2, 2, 2, 2), pk5(3, 3, 3, 3));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_after_ignored_start", 32'(in_ready), 1);
    beat(6'd1, 1'b1, pk16(5, 5, 5, 5), pk5(2, 2, 2, 2), pk5(3, 3, 3, 3));
    drain(1'b0, 1'b0, 64);

    // 256 beats of 0x7FFF into (0,0).
    do_start();
    for (int i = 0; i < 256; i++)
      beat(6'd2, i == 255, pk16(32'h7FFF, 0, 0, 0), pk5(0, 7, 7, 7), pk5(0, 7, 7, 7));
    drain(1'b0, 1'b0, 64);

    // Build 0x7FFFFF at (3,4), then add 1 to wrap to 0x800000.
    do_start();
    for (int i = 0; i < 64; i++)
      beat(6'd4, 1'b0, pk16(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF), pk5(3, 3, 3, 3), pk5(4, 4, 4, 4));
    beat(6'd4, 1'b0, pk16(255, 0, 0, 0), pk5(3, 3, 3, 3), pk5(4, 4, 4, 4));
    beat(6'd4, 1'b1, pk16(1, 0, 0, 0), pk5(3, 3, 3, 3), pk5(4, 4, 4, 4));
    drain(1'b0, 1'b0, 64);

    // Range drops: three out-of-range lanes plus (1,1)=7.
    do_start();
    beat(6'd7, 1'b1, pk16(11, 22, 33, 7), pk5(8, 0, 31, 1), pk5(0, 9, 31, 1));
    drain(1'b0, 1'b0, 64);

    // Channel mismatch on the last beat: dropped, tile still ends.
    do_start();
    beat(6'd5, 1'b0, pk16(1, 0, 0, 0), pk5(0, 0, 0, 0), pk5(0, 0, 0, 0));
    beat(6'd6, 1'b1, pk16(100, 0, 0, 0), pk5(0, 0, 0, 0), pk5(0, 0, 0, 0));
    drain(1'b0, 1'b0, 64);

    // Random beats, backpressured drain with in_valid poked during DRAIN.
    do_start();
    for (int i = 0; i < 3; i++)
      beat(6'd9, i == 2,
           pk16(int'($urandom), int'($urandom), int'($urandom), int'($urandom)),
           pk5(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 9)), int'($urandom_range(0, 9))),
           pk5(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 9)), int'($urandom_range(0, 9))));
    drain(1'b1, 1'b1, 64);

    // Reset in the middle of a drain, then an all-out-of-range tile.
    do_start();
    beat(6'd8, 1'b1, pk16(9, 9, 9, 9), pk5(1, 2, 3, 4), pk5(1, 2, 3, 4));
    drain(1'b0, 1'b0, 10);
    irst_n = 1'b0;
    @(negedge clk);
    irst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_row", 32'(out_row), 0);
    check("midrst_out_col", 32'(out_col), 0);
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_out_channel", 32'(out_channel), 0);
    sb.delete();
    @(negedge clk);
    do_start();
    beat(6'd3, 1'b1, pk16(5, 6, 7, 8), pk5(8, 9, 31, 0), pk5(0, 0, 31, 8));
    drain(1'b0, 1'b0, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
